ifft_stage_sched: RTL

- Sequencer for the 32-point radix-2 DIF IFFT datapath.
- Walks 5 stages × 16 butterflies.
- Per butterfly, issues sample-RAM read addresses and the twiddle select code to the pipelined complex multiplier / butterfly.
- Delays write-back addresses to match datapath latency, and drains the pipeline between stages so no stage reads data that has not been written.
- Sits between the frame controller (start/done) and the sample RAM + multiplier.

---
 rtl/ifft_pkg.sv | 51 +++++
 rtl/ifft_addr_delay.sv | 61 ++++++
 rtl/ifft_stage_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ifft_pkg.sv
// Shared definitions for the 32-point radix-2 DIF IFFT stage sequencer:
// geometry constants, the FSM state type and the address/twiddle helpers.
package ifft_pkg;

   localparam int N_PTS          = 32;
   localparam int N_STAGES       = 5;
   localparam int BFLY_PER_STAGE = N_PTS / 2;
   localparam int ADDR_W         = $clog2(N_PTS);
   localparam int TWSEL_W        = 7;
   localparam int STAGE_W        = 3;
   localparam int K_W            = $clog2(BFLY_PER_STAGE);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   // Butterfly span of a stage: 16, 8, 4, 2, 1 for stages 0..4.
   function automatic logic [ADDR_W-1:0] bfly_span(input logic [STAGE_W-1:0] stage);
      logic [ADDR_W-1:0] span0;
      span0 = ADDR_W'(BFLY_PER_STAGE);
      return span0 >> stage;
   endfunction

   // Upper-leg address: the group index (k above the span bits) is moved up
   // one bit to skip over the lower legs, the in-group offset stays in place.
   function automatic logic [ADDR_W-1:0] bfly_addr_a(input logic [STAGE_W-1:0] stage,
                                                     input logic [K_W-1:0]     k);
      logic [ADDR_W-1:0] lowMask;
      logic [ADDR_W-1:0] kExt;
      lowMask = bfly_span(stage) - ADDR_W'(1);
      kExt    = {1'b0, k};
      return ((kExt & ~lowMask) << 1) | (kExt & lowMask);
   endfunction

   // Lower-leg address: upper leg plus span; the span bit is always clear
   // in the upper-leg address, so an OR is enough.
   function automatic logic [ADDR_W-1:0] bfly_addr_b(input logic [STAGE_W-1:0] stage,
                                                     input logic [K_W-1:0]     k);
      return bfly_addr_a(stage, k) | bfly_span(stage);
   endfunction

   // Twiddle code 16*stage + k + 1; code 0 is reserved for "no twiddle".
   function automatic logic [TWSEL_W-1:0] twsel_code(input logic [STAGE_W-1:0] stage,
                                                    input logic [K_W-1:0]     k);
      return TWSEL_W'({stage, k}) + TWSEL_W'(1);
   endfunction

endpackage

// File: rtl/ifft_addr_delay.sv
// Write-back delay line: carries {valid, addr_a, addr_b} DEPTH cycles so the
// write strobe lines up with the datapath result. Also reports whether any
// entry is still travelling behind the output slot.
module ifft_addr_delay
   import ifft_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              clr_i,
   input  logic              valid_i,
   input  logic [ADDR_W-1:0] addr_a_i,
   input  logic [ADDR_W-1:0] addr_b_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_a_o,
   output logic [ADDR_W-1:0] addr_b_o,
   output logic              pending_o
);

   // Every slot except the output one; empty for a single-stage line.
   localparam logic [DEPTH-1:0] INNER_MASK = {DEPTH{1'b1}} >> 1;

   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0][ADDR_W-1:0] addrA_q, addrA_d;
   logic [DEPTH-1:0][ADDR_W-1:0] addrB_q, addrB_d;
   logic [DEPTH:0]               validChain;
   logic [(DEPTH+1)*ADDR_W-1:0]  addrAChain;
   logic [(DEPTH+1)*ADDR_W-1:0]  addrBChain;

   // Shift the new entry in at slot 0; the oldest entry falls off the top.
   always_comb begin
      validChain = {valid_q, valid_i};
      addrAChain = {addrA_q, addr_a_i};
      addrBChain = {addrB_q, addr_b_i};
      valid_d    = validChain[DEPTH-1:0];
      addrA_d    = addrAChain[DEPTH*ADDR_W-1:0];
      addrB_d    = addrBChain[DEPTH*ADDR_W-1:0];
   end

   // Delay-line storage; a clear drops every in-flight write at once.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         valid_q <= '0;
         addrA_q <= '0;
         addrB_q <= '0;
      end else begin
         valid_q <= valid_d;
         addrA_q <= addrA_d;
         addrB_q <= addrB_d;
      end
   end

   // Oldest slot drives the write port.
   always_comb begin
      valid_o   = valid_q[DEPTH-1];
      addr_a_o  = addrA_q[DEPTH-1];
      addr_b_o  = addrB_q[DEPTH-1];
      pending_o = |(valid_q & INNER_MASK);
   end

endmodule

// File: rtl/ifft_stage_sched.sv
// Stage/butterfly sequencer for the 32-point DIF IFFT. Issues one butterfly
// per cycle, delays the write-back addresses by the datapath latency and
// drains the pipe between stages so a stage never reads unwritten data.
module ifft_stage_sched
   import ifft_pkg::*;
#(
   parameter int RD_LAT  = 1,
   parameter int MUL_LAT = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               rd_en_o,
   output logic [ADDR_W-1:0]  rd_addr_a_o,
   output logic [ADDR_W-1:0]  rd_addr_b_o,
   output logic [TWSEL_W-1:0] twsel_o,
   output logic               wr_en_o,
   output logic [ADDR_W-1:0]  wr_addr_a_o,
   output logic [ADDR_W-1:0]  wr_addr_b_o,
   output logic [STAGE_W-1:0] stage_o
);

   localparam int                 PIPE_LAT   = RD_LAT + MUL_LAT;
   localparam logic [K_W-1:0]     LAST_K     = K_W'(BFLY_PER_STAGE - 1);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);

   state_t             state_q, state_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic [K_W-1:0]     k_q, k_d;
   logic               issue;
   logic               dlyValid;
   logic               dlyPending;
   logic [ADDR_W-1:0]  issueAddrA;
   logic [ADDR_W-1:0]  issueAddrB;

   // Sequencer state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         stage_q <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         k_q     <= k_d;
      end
   end

   // Next-state logic: issue 16 butterflies, drain until the stage's last
   // write is on the port, then move to the next stage or finish.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      k_d     = k_q;
      issue   = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = ISSUE;
               stage_d = '0;
               k_d     = '0;
            end
         end
         ISSUE: begin
            busy_o = 1'b1;
            issue  = 1'b1;
            k_d    = k_q + K_W'(1);
            if (k_q == LAST_K) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            busy_o = 1'b1;
            if (dlyValid && !dlyPending) begin
               if (stage_q == LAST_STAGE) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  stage_d = stage_q + STAGE_W'(1);
                  k_d     = '0;
               end
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
            stage_d = '0;
            k_d     = '0;
         end
         default: begin
            state_d = IDLE;
            stage_d = '0;
            k_d     = '0;
         end
      endcase
   end

   // Read-side outputs; addresses and twiddle are forced to zero when idle
   // so only real butterflies enter the write-back delay line.
   always_comb begin
      issueAddrA  = bfly_addr_a(stage_q, k_q);
      issueAddrB  = bfly_addr_b(stage_q, k_q);
      rd_en_o     = issue;
      rd_addr_a_o = issue ? issueAddrA : '0;
      rd_addr_b_o = issue ? issueAddrB : '0;
      twsel_o     = issue ? twsel_code(stage_q, k_q) : '0;
      stage_o     = stage_q;
   end

   ifft_addr_delay #(
      .DEPTH (PIPE_LAT)
   ) u_addr_delay (
      .clk_i     (clk_i),
      .clr_i     (rst_i),
      .valid_i   (issue),
      .addr_a_i  (rd_addr_a_o),
      .addr_b_i  (rd_addr_b_o),
      .valid_o   (dlyValid),
      .addr_a_o  (wr_addr_a_o),
      .addr_b_o  (wr_addr_b_o),
      .pending_o (dlyPending)
   );

   // Write strobe is the delay-line valid bit.
   always_comb begin
      wr_en_o = dlyValid;
   end

endmodule
